// File: rtl/decode_stage.sv
// decode_stage: buffered RV32I decode stage between fetch and issue.
//
// Fetch packets (PC + instruction) enter a DEPTH-entry FIFO through a
// valid/ready handshake. The FIFO head is decoded combinationally and
// loaded into a registered output stage toward issue.
//
// Optional feature macro: DECODE_RV32M_EN (adds RV32M decode as unit 3;
// without it those encodings are flagged illegal).
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   flush            drop all buffered and output state at the next edge
//   in_valid/ready   fetch handshake; in_pc [PC_W], in_instr [32]
//   out_valid/ready  issue handshake
//   out_pc [PC_W]    PC of the decoded packet
//   out_decode [16]  {unit[1:0], sub_unit[2:0], sel[3:0], imm, fence,
//                     ecall, ebreak, mret, illegal, calc_j}
//   out_rd/rs1/rs2   register indices, zero where the format has none
//   out_imm [XLEN]   sign-extended immediate (zimm/shamt zero-extended)
module decode_stage #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [15:0]     out_decode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [1:0]      unit;
    logic [2:0]      sub_unit;
    logic [3:0]      sel;
    logic            imm_f;
    logic            fence;
    logic            ecall;
    logic            ebreak;
    logic            mret;
    logic            illegal;
    logic            calc_j;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
  } dec_t;

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] ins);
    return $signed({{(XLEN-12){ins[31]}}, ins[31:20]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] ins);
    return $signed({{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] ins);
    return $signed({{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] ins);
    return XLEN'($signed({ins[31:12], 12'b0}));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] ins);
    return $signed({{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
  endfunction

  // 5-bit unsigned field (shamt or CSR zimm), zero-extended
  function automatic logic [XLEN-1:0] imm_z5(input logic [4:0] f);
    return XLEN'(f);
  endfunction

  function automatic dec_t decode_instr(input logic [31:0] ins);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    d  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b1;
    case (ins[6:0])
      OPC_LUI: begin
        d.sel   = 4'd0;
        d.imm_f = 1'b1;
        d.rd    = ins[11:7];
        d.imm   = imm_u(ins);
      end
      OPC_AUIPC: begin
        d.sel   = 4'd1;
        d.imm_f = 1'b1;
        d.rd    = ins[11:7];
        d.imm   = imm_u(ins);
      end
      OPC_JAL: begin
        d.sel   = 4'd2;
        d.imm_f = 1'b1;
        d.rd    = ins[11:7];
        d.imm   = imm_j(ins);
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          d.sel    = 4'd3;
          d.imm_f  = 1'b1;
          d.calc_j = 1'b1;
          d.rd     = ins[11:7];
          d.rs1    = ins[19:15];
          d.imm    = imm_i(ins);
        end else begin
          ok = 1'b0;
        end
      end
      OPC_BRANCH: begin
        d.sub_unit = 3'd1;
        d.imm_f    = 1'b1;
        d.calc_j   = 1'b1;
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.imm      = imm_b(ins);
        case (f3)
          3'b000:  d.sel = 4'd0;
          3'b001:  d.sel = 4'd1;
          3'b100:  d.sel = 4'd2;
          3'b101:  d.sel = 4'd3;
          3'b110:  d.sel = 4'd4;
          3'b111:  d.sel = 4'd5;
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.unit  = 2'd1;
        d.imm_f = 1'b1;
        d.rd    = ins[11:7];
        d.rs1   = ins[19:15];
        d.imm   = imm_i(ins);
        case (f3)
          3'b000:  d.sel = 4'd0;
          3'b001:  d.sel = 4'd1;
          3'b010:  d.sel = 4'd2;
          3'b100:  d.sel = 4'd3;
          3'b101:  d.sel = 4'd4;
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.unit     = 2'd1;
        d.sub_unit = 3'd1;
        d.imm_f    = 1'b1;
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.imm      = imm_s(ins);
        case (f3)
          3'b000:  d.sel = 4'd0;
          3'b001:  d.sel = 4'd1;
          3'b010:  d.sel = 4'd2;
          default: ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        d.imm_f = 1'b1;
        d.rd    = ins[11:7];
        d.rs1   = ins[19:15];
        d.imm   = imm_i(ins);
        case (f3)
          3'b000: d.sub_unit = 3'd2;
          3'b010: begin d.sub_unit = 3'd3; d.sel = 4'd0; end
          3'b011: begin d.sub_unit = 3'd3; d.sel = 4'd1; end
          3'b100: begin d.sub_unit = 3'd3; d.sel = 4'd2; end
          3'b110: begin d.sub_unit = 3'd3; d.sel = 4'd3; end
          3'b111: begin d.sub_unit = 3'd3; d.sel = 4'd4; end
          3'b001: begin
            d.sub_unit = 3'd4;
            d.sel      = 4'd0;
            d.imm      = imm_z5(ins[24:20]);
            ok         = (f7 == 7'b0000000);
          end
          default: begin
            d.sub_unit = 3'd4;
            d.imm      = imm_z5(ins[24:20]);
            if (f7 == 7'b0000000)      d.sel = 4'd1;
            else if (f7 == 7'b0100000) d.sel = 4'd2;
            else                       ok = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        d.rd  = ins[11:7];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  begin d.sub_unit = 3'd2; d.sel = 4'd0; end
              3'b001:  begin d.sub_unit = 3'd4; d.sel = 4'd0; end
              3'b010:  begin d.sub_unit = 3'd3; d.sel = 4'd0; end
              3'b011:  begin d.sub_unit = 3'd3; d.sel = 4'd1; end
              3'b100:  begin d.sub_unit = 3'd3; d.sel = 4'd2; end
              3'b101:  begin d.sub_unit = 3'd4; d.sel = 4'd1; end
              3'b110:  begin d.sub_unit = 3'd3; d.sel = 4'd3; end
              default: begin d.sub_unit = 3'd3; d.sel = 4'd4; end
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  begin d.sub_unit = 3'd2; d.sel = 4'd1; end
              3'b101:  begin d.sub_unit = 3'd4; d.sel = 4'd2; end
              default: ok = 1'b0;
            endcase
          end
          7'b0000001: begin
`ifdef DECODE_RV32M_EN
            d.unit     = 2'd3;
            d.sub_unit = {2'b00, f3[2]};
            d.sel      = {2'b00, f3[1:0]};
`else
            ok = 1'b0;
`endif
          end
          default: ok = 1'b0;
        endcase
      end
      OPC_FENCE: begin
        if (f3 == 3'b000 || f3 == 3'b001) d.fence = 1'b1;
        else                              ok = 1'b0;
      end
      OPC_SYSTEM: begin
        case (f3)
          3'b000: begin
            if (ins == 32'h0000_0073)      d.ecall  = 1'b1;
            else if (ins == 32'h0010_0073) d.ebreak = 1'b1;
            else if (ins == 32'h3020_0073) d.mret   = 1'b1;
            else                           ok = 1'b0;
          end
          3'b100: ok = 1'b0;
          default: begin
            // f3[1:0] = 01/10/11 -> rw/rs/rc; f3[2] selects the zimm form
            d.unit = 2'd2;
            d.sel  = {2'b00, f3[1:0]} - 4'd1;
            d.rd   = ins[11:7];
            if (f3[2]) begin
              d.imm_f = 1'b1;
              d.imm   = imm_z5(ins[19:15]);
            end else begin
              d.rs1 = ins[19:15];
            end
          end
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  logic             vld_p1;
  logic [PC_W-1:0]  pc_p1;
  logic [15:0]      dec_vec_p1;
  logic [4:0]       rd_p1;
  logic [4:0]       rs1_p1;
  logic [4:0]       rs2_p1;
  logic [XLEN-1:0]  imm_p1;

  logic [PC_W-1:0]  head_pc_p0;
  logic [31:0]      head_instr_p0;
  dec_t             dec_p0;

  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = (count != '0) & (~vld_p1 | out_ready);

  // ---- stage p0: FIFO storage and head decode ----
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop)            vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
    end
  end

  assign head_pc_p0    = pc_mem[rd_ptr];
  assign head_instr_p0 = instr_mem[rd_ptr];
  assign dec_p0        = decode_instr(head_instr_p0);

  // ---- stage p1: registered decode toward issue ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1      <= '0;
      dec_vec_p1 <= '0;
      rd_p1      <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      imm_p1     <= '0;
    end else if (pop && !flush) begin
      pc_p1      <= head_pc_p0;
      dec_vec_p1 <= {dec_p0.unit, dec_p0.sub_unit, dec_p0.sel, dec_p0.imm_f,
                     dec_p0.fence, dec_p0.ecall, dec_p0.ebreak, dec_p0.mret,
                     dec_p0.illegal, dec_p0.calc_j};
      rd_p1      <= dec_p0.rd;
      rs1_p1     <= dec_p0.rs1;
      rs2_p1     <= dec_p0.rs2;
      imm_p1     <= dec_p0.imm;
    end
  end

  assign out_valid  = vld_p1;
  assign out_pc     = pc_p1;
  assign out_decode = dec_vec_p1;
  assign out_rd     = rd_p1;
  assign out_rs1    = rs1_p1;
  assign out_rs2    = rs2_p1;
  assign out_imm    = imm_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a queue scoreboard: an expected
// record is queued whenever a packet is accepted and popped when issue
// accepts the decoded packet.
module tb_decode_stage;

  localparam int NT = 23;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [15:0] out_decode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;

  decode_stage #(.DEPTH(4), .PC_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_decode(out_decode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] instr;
    logic [15:0] dec;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } entry_t;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] dec;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } exp_t;

  entry_t tbl [NT];
  exp_t   sb [$];
  exp_t   cur_exp;
  int     compared;
  int     mismatched;
  int     cyc;
  logic   last_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update scoreboard after.
  task automatic tick();
    logic fi;
    logic fo;
    exp_t got;
    exp_t e;
    fi  = in_valid && in_ready && !flush && !rst;
    fo  = out_valid && out_ready && !flush && !rst;
    got = '{out_pc, out_decode, out_rd, out_rs1, out_rs2, out_imm};
    @(posedge clk);
    #1;
    cyc++;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (fo) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_pc", got.pc, e.pc);
          check("sb_decode", 32'(got.dec), 32'(e.dec));
          check("sb_rd", 32'(got.rd), 32'(e.rd));
          check("sb_rs1", 32'(got.rs1), 32'(e.rs1));
          check("sb_rs2", 32'(got.rs2), 32'(e.rs2));
          check("sb_imm", got.imm, e.imm);
        end
      end
      if (fi) sb.push_back(cur_exp);
    end
    last_fire = fi;
  endtask

  // Present one packet and hold it until accepted (bounded).
  task automatic send_pkt(input int idx, input logic [31:0] pc);
    int n;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = tbl[idx].instr;
    cur_exp  = '{pc, tbl[idx].dec, tbl[idx].rd, tbl[idx].rs1, tbl[idx].rs2, tbl[idx].imm};
    n = 0;
    last_fire = 1'b0;
    while (!last_fire && n < 20) begin
      tick();
      n++;
    end
    check("accept", 32'(last_fire), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int c0;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    last_fire  = 1'b0;

    tbl[0]  = '{32'h00500093, 16'h1040, 5'd1, 5'd0, 5'd0, 32'd5};
    tbl[1]  = '{32'h40315113, 16'h2140, 5'd2, 5'd2, 5'd0, 32'd3};
    tbl[2]  = '{32'h00000073, 16'h0010, 5'd0, 5'd0, 5'd0, 32'd0};
    tbl[3]  = '{32'hFFFFFFFF, 16'h0002, 5'd0, 5'd0, 5'd0, 32'd0};
`ifdef DECODE_RV32M_EN
    tbl[4]  = '{32'h022081B3, 16'hC000, 5'd3, 5'd1, 5'd2, 32'd0};
`else
    tbl[4]  = '{32'h022081B3, 16'h0002, 5'd0, 5'd0, 5'd0, 32'd0};
`endif
    tbl[5]  = '{32'h002081B3, 16'h1000, 5'd3, 5'd1, 5'd2, 32'd0};
    tbl[6]  = '{32'h402081B3, 16'h1080, 5'd3, 5'd1, 5'd2, 32'd0};
    tbl[7]  = '{32'h00208463, 16'h0841, 5'd0, 5'd1, 5'd2, 32'd8};
    tbl[8]  = '{32'hFE001EE3, 16'h08C1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC};
    tbl[9]  = '{32'hFF812283, 16'h4140, 5'd5, 5'd2, 5'd0, 32'hFFFFFFF8};
    tbl[10] = '{32'h00612623, 16'h4940, 5'd0, 5'd2, 5'd6, 32'd12};
    tbl[11] = '{32'h123453B7, 16'h0040, 5'd7, 5'd0, 5'd0, 32'h12345000};
    tbl[12] = '{32'h010000EF, 16'h0140, 5'd1, 5'd0, 5'd0, 32'd16};
    tbl[13] = '{32'h00008067, 16'h01C1, 5'd0, 5'd1, 5'd0, 32'd0};
    tbl[14] = '{32'h300092F3, 16'h8000, 5'd5, 5'd1, 5'd0, 32'd0};
    tbl[15] = '{32'h30046073, 16'h80C0, 5'd0, 5'd0, 5'd0, 32'd8};
    tbl[16] = '{32'h0FF0000F, 16'h0020, 5'd0, 5'd0, 5'd0, 32'd0};
    tbl[17] = '{32'h00100073, 16'h0008, 5'd0, 5'd0, 5'd0, 32'd0};
    tbl[18] = '{32'h30200073, 16'h0004, 5'd0, 5'd0, 5'd0, 32'd0};
    tbl[19] = '{32'hFFF24213, 16'h1940, 5'd4, 5'd4, 5'd0, 32'hFFFFFFFF};
    tbl[20] = '{32'h002091B3, 16'h2000, 5'd3, 5'd1, 5'd2, 32'd0};
    tbl[21] = '{32'h4020D1B3, 16'h2100, 5'd3, 5'd1, 5'd2, 32'd0};
    tbl[22] = '{32'h0020A463, 16'h0002, 5'd0, 5'd0, 5'd0, 32'd0};

    // Reset held two cycles with in_valid high
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_0040;
    in_instr  = 32'h00500093;
    out_ready = 1'b1;
    cur_exp   = '{32'd0, 16'd0, 5'd0, 5'd0, 5'd0, 32'd0};
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_decode", 32'(out_decode), 32'h0);
    end
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_imm", out_imm, 32'h0);
    check("rst_out_rd", 32'(out_rd), 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_out_decode", 32'(out_decode), 32'h0);

    // Single ADDI: two edges from push to out_valid
    send_pkt(0, 32'h100);
    in_valid = 1'b0;
    check("addi_lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_decode", 32'(out_decode), 32'h1040);
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_rs1", 32'(out_rs1), 32'd0);
    check("addi_rs2", 32'(out_rs2), 32'd0);
    check("addi_imm", out_imm, 32'd5);
    check("addi_pc", out_pc, 32'h100);
    drain();
    check("addi_idle", 32'(out_valid), 32'd0);

    // Full decode table at one packet per cycle
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < NT; i++) send_pkt(i, 32'h1000 + 32'(i * 4));
    check("throughput_cycles", 32'(cyc - c0), 32'(NT));
    in_valid = 1'b0;
    drain();

    // Back-pressure: five packets against a stalled output
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_pkt(5 + i, 32'h3000 + 32'(i * 4));
    in_valid = 1'b0;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_pc", out_pc, 32'h3000);
      check("bp_hold_decode", 32'(out_decode), 32'(tbl[5].dec));
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drain();
    check("bp_idle", 32'(out_valid), 32'd0);

    // Flush with three entries buffered and a packet offered
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pkt(10 + i, 32'h4000 + 32'(i * 4));
    check("fl_pre_in_ready", 32'(in_ready), 32'd1);
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'hDEAD_0000;
    in_instr = 32'h00500093;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_nothing_out", 32'(out_valid), 32'd0);
    end
    send_pkt(19, 32'h5000);
    in_valid = 1'b0;
    tick();
    check("fl_resume_pc", out_pc, 32'h5000);
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(20 + i, 32'h6000 + 32'(i * 4));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_decode", 32'(out_decode), 32'h0);
    check("mr_out_pc", out_pc, 32'h0);
    check("mr_out_imm", out_imm, 32'h0);
    out_ready = 1'b1;
    tick();
    check("mr_in_ready_after", 32'(in_ready), 32'd1);
    check("mr_out_valid_after", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, buffered RV32I instruction decode stage placed between fetch and issue. It accepts fetch packets (PC and instruction) through a valid/ready handshake into a DEPTH-entry FIFO and decodes the head entry. It registers a wide decode vector, register indices and a sign-extended immediate toward issue. The stage supports back-pressure, pipeline flush and optional RV32M decode.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- PC_W, 32: PC width.
- XLEN, 32: immediate width; fixed at 32 in this generation.
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered and output state.
- in_valid  in  1  fetch packet valid.
- in_ready  out  1  FIFO can accept.
- in_pc  in  PC_W  packet PC.
- in_instr  in  32  packet instruction.
- out_valid  out  1  decoded packet valid.
- out_ready  in  1  issue accepts.
- out_pc  out  PC_W  PC of decoded packet.
- out_decode  out  16  {unit[1:0], sub_unit[2:0], sel[3:0], imm, fence, ecall, ebreak, mret, illegal, calc_j}.
- out_rd, out_rs1, out_rs2  out  5 each  register indices; zero where the format has none.
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode; zimm zero-extended for CSR*I); 0 for R-type.

## Operation
- FIFO: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH+1) bits.
- in_ready = (count != DEPTH), taken from registered count only. There is no same-cycle pass-through when full.
- Push = in_valid & in_ready & ~flush.
- Output register: loaded from the FIFO head when count≠0 and (~out_valid | out_ready). The head pops in the same cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Decode unit/sub_unit/sel encoding:
  - ALU (unit 0): special lui/auipc/jal/jalr = 0..3; branch beq..bgeu = 0..5; add add/addi = 0, sub = 1; logic slt/sltu/xor/or/and = 0..4; shift sll = 0, srl = 1, sra = 2.
  - Load/store (unit 1): load lb/lh/lw/lbu/lhu = 0..4; store sb/sh/sw = 0..2.
  - CSR (unit 2): rw/rs/rc = 0/1/2, sub_unit 0.
- Shift decode: SRAI and SRA both give sel = 2.
- imm bit: set for every immediate form.
- calc_j: set for jalr and all branches.
- mret: has its own bit; unit, sub_unit and sel are 0.
- fence, fence.i, ecall, ebreak: flag only, all other fields 0.
- Any unmatched encoding sets illegal = 1 with every other field 0.
- Undriven fields default to 0. No latches; every output is fully assigned.
- flush: at the edge, count, both pointers and out_valid go to 0. A push in the same cycle is dropped. flush dominates pop and load.
- rst: same effect as flush, and also clears all output data registers.

## Timing
- Reset values: in_ready = 1, out_valid = 0, and every other output is 0.
- Latency: a packet pushed at edge E shows out_valid = 1 after edge E+1, provided the FIFO was empty and the output register was free.
- Throughput: one packet per cycle when out_ready is held high.
- out_* hold their values while out_valid & ~out_ready.
- Reset asserted mid-stream: state is cleared at the next edge, and in_ready = 1 in the cycle after.
- Pushing while full is not possible, because in_ready is low.

## Configuration
- DECODE_RV32M_EN defined:
  - opcode 0110011 with funct7 0000001 decodes to unit 3.
  - sub_unit = 0 for mul/mulh/mulhsu/mulhu, with sel = funct3[1:0].
  - sub_unit = 1 for div/divu/rem/remu, with sel = funct3[1:0].
- DECODE_RV32M_EN undefined: those encodings set illegal = 1.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 → in_ready = 1, out_valid = 0, out_decode = 0x0000 during reset and the first cycle after.
- Single ADDI: push ADDI 0x00500093 at PC 0x100 → two edges later out_valid = 1, out_decode = 0x1040, rd = 1, rs1 = 0, imm = 5, pc = 0x100.
- Back-pressure: out_ready = 0, push 5 packets with DEPTH = 4 →
  - 4 packets are accepted into the FIFO, the 5th is accepted once the output register frees a slot, then in_ready = 0.
  - Release out_ready → all packets arrive in order with no loss or duplication.
- Flush: flush while 3 entries are buffered and in_valid = 1 → next cycle count = 0, out_valid = 0, the flushed-cycle packet never appears.
- SRAI and ECALL:
  - 0x40315113 → unit 0, sub_unit 4, sel 2, imm = 3, rd = rs1 = 2.
  - 0x00000073 → ecall = 1 only.
  - 0xFFFFFFFF → illegal = 1 only.
- M extension: MUL 0x022081B3 → with DECODE_RV32M_EN: unit 3, sub_unit 0, sel 0, rd = 3, rs1 = 1, rs2 = 2; without it: illegal = 1.
